// File: rtl/serial_tx_shifter_pkg.sv
// Shared definitions for the serial transmitter: FSM state encodings and
// a helper for sizing small counters.
package serial_tx_defs;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_shifter_baud.sv
// Bit-period counter: counts enabled cycles 0..CLKS_PER_BIT-1 and flags the
// last cycle of each serial bit.
module baud_tick_counter
  import serial_tx_defs::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // With CLKS_PER_BIT=1 the count stays at 0 and tick is permanently high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (clear || tick) cnt <= '0;
      else               cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx_shifter.sv
// Parallel-in serial-out framer: start bit, data LSB first, optional even
// parity, stop bit, each held CLKS_PER_BIT enabled cycles.
module serial_tx_shifter
  import serial_tx_defs::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_e             state,  state_nxt;
  logic [DATA_WIDTH-1:0] shreg,  shreg_nxt;
  logic [BW-1:0]         bitcnt, bitcnt_nxt;
  logic                  par,    par_nxt;
  logic                  txo_nxt;
  logic                  busy_nxt;
  logic                  tick;
  logic                  accept;

  assign tx_ready = (state == IDLE) && en;
  assign accept   = tx_valid && tx_ready;

  // Held in clear while idle so the first bit of a frame gets a full period.
  baud_tick_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    par_nxt    = par;
    txo_nxt    = tx_out;
    busy_nxt   = busy;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = START;
          shreg_nxt  = tx_data;
          par_nxt    = ^tx_data;
          bitcnt_nxt = '0;
          txo_nxt    = 1'b0;
          busy_nxt   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_nxt = DATA;
          txo_nxt   = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bitcnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_nxt = PARITY;
              txo_nxt   = par;
            end else begin
              state_nxt = STOP;
              txo_nxt   = 1'b1;
            end
          end else begin
            shreg_nxt  = shreg >> 1;
            bitcnt_nxt = bitcnt + BW'(1);
            txo_nxt    = shreg_nxt[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_nxt = STOP;
          txo_nxt   = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          txo_nxt   = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        txo_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // A low enable freezes every register, so a pause only stretches the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      par    <= 1'b0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
    end else if (en) begin
      state  <= state_nxt;
      shreg  <= shreg_nxt;
      bitcnt <= bitcnt_nxt;
      par    <= par_nxt;
      tx_out <= txo_nxt;
      busy   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: three configurations (default, even parity,
// one clock per bit) driven by a stimulus thread and checked by a frame monitor.
module tb_serial_tx_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_s[3];
  logic       valid_s[3];
  logic [7:0] data_s[3];
  logic       ready_w[3];
  logic       out_w[3];
  logic       busy_w[3];

  serial_tx_shifter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_s[0]), .tx_data(data_s[0]), .tx_valid(valid_s[0]),
    .tx_ready(ready_w[0]), .tx_out(out_w[0]), .busy(busy_w[0]));
  serial_tx_shifter #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_s[1]), .tx_data(data_s[1]), .tx_valid(valid_s[1]),
    .tx_ready(ready_w[1]), .tx_out(out_w[1]), .busy(busy_w[1]));
  serial_tx_shifter #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_s[2]), .tx_data(data_s[2]), .tx_valid(valid_s[2]),
    .tx_ready(ready_w[2]), .tx_out(out_w[2]), .busy(busy_w[2]));

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t exp_q[3][$];
  exp_t cur[3];
  bit   active[3];
  int   k[3];
  int   end_cyc[3];
  logic edge_en[3];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) edge_en[g] <= en_s[g];
  end

  function automatic int cpb(input int g);
    return (g == 2) ? 1 : 4;
  endfunction

  function automatic int pen(input int g);
    return (g == 1) ? 1 : 0;
  endfunction

  // Line level expected at frame bit position idx.
  function automatic int exp_bit(input logic [7:0] d, input int idx, input int p);
    if (idx == 0) return 0;
    if (idx <= 8) return int'(d[idx-1]);
    if (idx == 9 && p != 0) return int'(^d);
    return 1;
  endfunction

  task automatic check(input string name, input int g, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %0d, expected %0d", name, g, cyc, act, exp);
  endtask

  // Monitor: follows each frame by counting enabled cycles since its start.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        active[g] = 1'b0;
        check("rst_out", g, int'(out_w[g]), 1);
        check("rst_busy", g, int'(busy_w[g]), 0);
        check("rst_ready", g, int'(ready_w[g]), int'(en_s[g]));
      end else if (!active[g]) begin
        if (busy_w[g]) begin
          if (exp_q[g].size() == 0) begin
            check("unexpected_frame", g, 1, 0);
          end else begin
            cur[g] = exp_q[g].pop_front();
            active[g] = 1'b1;
            k[g] = 0;
            check("start_cycle", g, cyc, cur[g].cyc);
            check("start_bit", g, int'(out_w[g]), 0);
            check("busy_ready", g, int'(ready_w[g]), 0);
          end
        end else begin
          check("idle_out", g, int'(out_w[g]), 1);
          check("idle_ready", g, int'(ready_w[g]), int'(en_s[g]));
        end
      end else begin
        if (edge_en[g]) k[g]++;
        if (k[g] == (10 + pen(g)) * cpb(g)) begin
          check("busy_fall", g, int'(busy_w[g]), 0);
          check("end_out", g, int'(out_w[g]), 1);
          check("end_ready", g, int'(ready_w[g]), int'(en_s[g]));
          active[g] = 1'b0;
          end_cyc[g] = cyc;
        end else begin
          check("busy", g, int'(busy_w[g]), 1);
          check("line", g, int'(out_w[g]), exp_bit(cur[g].d, k[g] / cpb(g), pen(g)));
          check("busy_ready", g, int'(ready_w[g]), 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d, input bit hold, output int acc);
    exp_t e;
    step();
    data_s[i]  = d;
    valid_s[i] = 1'b1;
    en_s[i]    = 1'b1;
    acc = -1;
    for (int t = 0; t < 200 && acc < 0; t++) begin
      @(posedge clk);
      if (valid_s[i] && ready_w[i]) begin
        acc = cyc + 1;
        e.d = d;
        e.cyc = acc;
        exp_q[i].push_back(e);
      end
      #1;
    end
    check("accept_timeout", i, int'(acc >= 0), 1);
    if (!hold) valid_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input bit rand_en);
    int t;
    t = 0;
    while ((active[i] || exp_q[i].size() != 0) && t < 3000) begin
      step();
      if (rand_en) en_s[i] = ($urandom_range(0, 3) != 0);
      t++;
    end
    en_s[i] = 1'b1;
    check("frame_done_timeout", i, int'(t < 3000), 1);
  endtask

  initial begin
    int a, b;
    logic [7:0] rd;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      en_s[g] = 1'b0;
      valid_s[g] = 1'b1;
      data_s[g] = 8'h00;
    end
    repeat (3) step();
    for (int g = 0; g < 3; g++) begin
      valid_s[g] = 1'b0;
      en_s[g] = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 0, int'(ready_w[0]), 1);

    // Single frames, default and with parity.
    send(0, 8'hA5, 1'b0, a);
    wait_done(0, 1'b0);
    check("frame_len_a5", 0, end_cyc[0] - a, 40);
    send(1, 8'h07, 1'b0, a);
    wait_done(1, 1'b0);
    check("frame_len_par", 1, end_cyc[1] - a, 44);

    // Back-to-back with tx_valid held high.
    send(0, 8'h01, 1'b1, a);
    send(0, 8'hFF, 1'b0, b);
    check("b2b_period", 0, b - a, 41);
    check("b2b_gap", 0, b - end_cyc[0], 1);
    wait_done(0, 1'b0);

    // Enable pause inside data bit 3.
    send(0, 8'h55, 1'b0, a);
    while (cyc < a + 17) step();
    en_s[0] = 1'b0;
    repeat (7) step();
    en_s[0] = 1'b1;
    wait_done(0, 1'b0);
    check("frame_len_pause", 0, end_cyc[0] - a, 47);

    // Asynchronous reset during data bit 5, then a clean frame.
    send(0, 8'hC3, 1'b0, a);
    while (cyc < a + 25) step();
    #2;
    rst_n = 1'b0;
    exp_q[0].delete();
    #1;
    check("async_rst_out", 0, int'(out_w[0]), 1);
    check("async_rst_busy", 0, int'(busy_w[0]), 0);
    step();
    step();
    rst_n = 1'b1;
    send(0, 8'h3C, 1'b0, a);
    wait_done(0, 1'b0);
    check("frame_len_3c", 0, end_cyc[0] - a, 40);

    // Random payloads with random enable gaps on every configuration.
    for (int n = 0; n < 6; n++) begin
      for (int g = 0; g < 3; g++) begin
        rd = 8'($urandom);
        send(g, rd, 1'b0, a);
        wait_done(g, 1'b1);
      end
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_tx_shifter.md
Name: serial_tx_shifter

Overview:
Parallel-in, serial-out transmitter: accepts a DATA_WIDTH word over a valid/ready handshake and shifts it onto a single line as a framed bit stream (start, data LSB-first, optional even parity, stop).
It is the sending end of the single-wire capture path built from our enabled D flip-flops. The receiver samples tx_out one bit per CLKS_PER_BIT cycles.
It is a basic-code sequential-logic block and has no bus attachment.

Parameters:
DATA_WIDTH, 8, payload bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  global enable; low freezes all state
tx_data  input  DATA_WIDTH  word to send; sampled only on accept
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word
tx_out  output  1  serial line; idles high
busy  output  1  a frame is in progress

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed): state=IDLE, tx_out=1, busy=0, shift register=0, bit counter=0, period counter=0.
- tx_ready is driven as (state==IDLE) && en.
- All other outputs are registered.
- Accept: a word is accepted on the rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register.
  - Parity is the XOR of tx_data, latched at accept.
  - state becomes START, tx_out becomes 0 and busy becomes 1, all on that same edge.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY after DATA_WIDTH bits if PARITY_EN=1; otherwise DATA -> STOP.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Levels on tx_out by state:
  - START: 0.
  - DATA: shift register bit 0. The register shifts right by 1 at each bit boundary, and the bit counter increments.
  - PARITY: the latched parity bit.
  - STOP: 1.
  - IDLE: 1.
- Bit timing:
  - A period counter of width clog2(CLKS_PER_BIT), minimum 1, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Every bit is held exactly CLKS_PER_BIT enabled cycles.
  - CLKS_PER_BIT=1 must work: one bit per cycle, with no counter-related glitch.
- Frame length: (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT enabled cycles, from the accept edge to the edge where state returns to IDLE.
- busy falls on the same edge that state returns to IDLE.
- Back-to-back frames: tx_valid held high gives a new accept on the first edge in IDLE. The stop bit is therefore effectively stretched by one cycle; the minimum inter-frame gap is 1 cycle.
- en low:
  - State, counters, shift register and tx_out hold their values.
  - tx_ready=0, so no accept is possible.
  - The frame resumes exactly where it left off when en returns high. Pausing mid-bit extends only that bit.
- tx_data and tx_valid changes after accept are ignored until IDLE.
- tx_valid asserted while busy: ignored, with no error. The word must be held by the sender until tx_ready.
- rst_n asserted mid-frame: the frame is aborted, tx_out goes to 1 immediately and state goes to IDLE. No partial frame resumes after reset.

Decomposition:
- Shared package / include serial_tx_defs: state encodings as localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4) and the 3-bit state width.
- Sub-module baud_tick_counter:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst_n, en, clear.
  - Output tick, high on the last cycle of each bit period.
- The FSM and shift register stay in serial_tx_shifter.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with tx_valid=1 -> tx_out=1, tx_ready=0 (asserted as 0 while rst_n is low), busy=0 throughout. Release rst_n with en=1 -> tx_ready=1 on the next cycle.
2. Single frame, defaults: tx_data=8'hA5 and tx_valid for 1 cycle -> tx_out=0,1,0,1,0,0,1,0,1,1, each value held 4 cycles. busy is high for exactly 40 cycles, then tx_ready=1.
3. Parity: PARITY_EN=1, tx_data=8'h07 -> after data bits 1,1,1,0,0,0,0,0 the parity bit=1, then stop=1. Frame is 44 cycles.
4. Back-to-back: tx_valid held high with 8'h01 then 8'hFF -> the second start bit begins 1 cycle after the first frame's stop ends. Second data is all 1s.
5. Enable pause: drop en for 7 cycles during data bit 3 of 8'h55 -> tx_out holds 0 for 4+7 cycles. Remaining bits are unchanged; the frame is 47 cycles.
6. Mid-frame reset: pulse rst_n low during data bit 5 -> tx_out=1 asynchronously, busy=0. A new frame with 8'h3C after release is transmitted correctly.
